sprite_blit_engine: RTL and testbench
=====================================

# sprite_blit_engine

Parametrised sprite blitter for the 320x240, 3-bit-colour VGA path. On a start handshake it sweeps a SPR_W x SPR_H rectangle at a runtime position and emits one pixel write per clock. Each pixel is either a solid fill colour (erase) or read from a sprite ROM, optionally with a transparent key colour. It replaces the fixed-size, fixed-position per-picture draw/erase FSMs. Its x/y/colour/plot outputs go to the VGA adapter through the existing plot arbiter.

## Interface
- SPR_W, 128, sprite width in pixels, 1..320, any value.
- SPR_H, 64, sprite height in pixels, 1..240, any value.
- ADDR_W, $clog2(SPR_W*SPR_H), sprite ROM address width.
- COLOUR_W, 3, colour width.
- KEY_COLOUR, 3'b000, transparent colour in MODE_KEYED.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- mode  in  2  00 MODE_FILL, 01 MODE_DRAW, 10 MODE_KEYED, 11 reserved (treated as MODE_FILL).
- pos_x  in  9  top-left x; latched at accept.
- pos_y  in  8  top-left y; latched at accept.
- fill_colour  in  COLOUR_W  fill colour; latched at accept.
- rom_addr  out  ADDR_W  sprite ROM address.
- rom_q  in  COLOUR_W  ROM data; valid one clock after rom_addr.
- x  out  9, y  out  8, colour  out  COLOUR_W  pixel write.
- plot  out  1  pixel write strobe.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at completion.

## Operation
- Reset is decided as stated above: reset reset, synchronous, active-high; clock clock.
- Reset state: IDLE, col=row=0. x=0, y=0, colour=0, plot=0, busy=0, done=0, rom_addr=0.
- States: IDLE -> RUN on start. RUN -> FLUSH after issuing pixel N-1, where N=SPR_W*SPR_H. FLUSH lasts 2 cycles to drain the pipe, then DONE. DONE lasts 1 cycle (done=1), then IDLE.
- Accept: start=1 in IDLE. Latch pos_x, pos_y, fill_colour and mode. start in any other state is ignored, not queued.
- Sweep: col counts 0..SPR_W-1. On wrap, col returns to 0 and row increments, up to SPR_H-1. Order is raster, row-major.
- rom_addr = row*SPR_W + col, kept as a running linear counter with no multiplier. rom_addr is driven in every mode; the ROM is ignored in MODE_FILL.
- Coordinates: px = pos_x + col and py = pos_y + row, computed at 10 and 9 bits respectively.
- Clipping: a pixel with px>=320 or py>=240 is suppressed (plot=0). The sweep still advances, so total duration does not depend on position.
- Colour: MODE_FILL gives fill_colour. MODE_DRAW gives rom_q. MODE_KEYED gives rom_q, with plot suppressed when rom_q==KEY_COLOUR.
- x and y are the low 9 and 8 bits of px and py. When plot=0, x, y and colour hold their last values.

## Timing
- Pipeline, 3 stages:
  - C0: rom_addr is issued from the counters.
  - C1: stage register holds px, py and valid, aligned with rom_q.
  - C2: registered outputs x, y, colour and plot.
- Start sampled at edge e. RUN is the cycle after e. The first plot occurs 2 cycles into RUN.
- Throughput is 1 pixel per clock with no gaps.
- The last plot occurs in FLUSH cycle 2. done is high in the following cycle; busy falls in the same cycle done pulses.
- Start to done is N+3 cycles after the accepting edge. Back-to-back: a start in the cycle after done is accepted.
- Reset mid-operation wins: next cycle is IDLE with all outputs at reset values. Pixels in flight are discarded and no done pulse is issued.
- SPR_W=1 or SPR_H=1 must work: col wraps every cycle, or row never increments.

## Structure
- Package blit_pkg holds:
  - mode encodings MODE_FILL/DRAW/KEYED;
  - state encoding IDLE/RUN/FLUSH/DONE;
  - SCREEN_W=320 and SCREEN_H=240;
  - COORD_X_W=9 and COORD_Y_W=8.
- One sub-module, blit_raster_counter: col, row and linear addr counter with clear, advance and last outputs, parametrised by SPR_W and SPR_H.
- Sprite ROM is external. Each picture instantiates its own ROM and one engine with matching SPR_W/SPR_H.

## Test plan
- Parameters SPR_W=4, SPR_H=2. Stimulus: MODE_FILL, pos (100,55), fill 3'b111. Response: 8 consecutive plots, (100,55)..(103,55) then (100,56)..(103,56), all colour 7. done occurs 11 cycles after accept.
- MODE_DRAW, ROM preloaded with 0..7, pos (0,0). Response: colour sequence 0,1,...,7 aligned with raster order, showing ROM latency alignment.
- MODE_KEYED, ROM pattern 0,5,0,5,... Response: plot only at col 1 and col 3, colour 5. done timing is unchanged.
- pos (318,239). Response: only (318,239) and (319,239) plotted; the other 6 pixels are suppressed. Still N+3 cycles.
- start held high for 20 cycles. Response: exactly one sweep accepted while busy, then a second accept in the cycle after done.
- reset asserted at the 4th plot. Response: next cycle plot=0, busy=0, done never pulses. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared encodings, screen geometry and helpers for the sprite blit engine.
package blit_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;
  localparam int unsigned COORD_X_W = 9;
  localparam int unsigned COORD_Y_W = 8;
  // Unclipped coordinates carry one extra bit so off-screen pixels are detectable.
  localparam int unsigned PX_W      = COORD_X_W + 1;
  localparam int unsigned PY_W      = COORD_Y_W + 1;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'b00,
    MODE_DRAW  = 2'b01,
    MODE_KEYED = 2'b10
  } blit_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    DONE  = 2'b11
  } blit_state_e;

  // C1 stage payload: unclipped pixel coordinate aligned with rom_q.
  typedef struct packed {
    logic            valid;
    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;
  } blit_stage_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reserved encoding falls back to fill.
  function automatic blit_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_DRAW;
      2'b10:   return MODE_KEYED;
      default: return MODE_FILL;
    endcase
  endfunction

endpackage

// File: rtl/blit_raster_counter.sv
// Raster-order col/row sweep with a running linear address (no multiplier).
module blit_raster_counter
  import blit_pkg::*;
#(
  parameter int unsigned SPR_W  = 128,
  parameter int unsigned SPR_H  = 64,
  parameter int unsigned COL_W  = cnt_w(SPR_W),
  parameter int unsigned ROW_W  = cnt_w(SPR_H),
  parameter int unsigned ADDR_W = cnt_w(SPR_W * SPR_H)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [COL_W-1:0] COL_MAX      = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX      = ROW_W'(SPR_H - 1);
  localparam logic             LAST_AT_ZERO = (SPR_W == 1) && (SPR_H == 1);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;

  // Next-state: clear wins over advance; the final pixel wraps everything to zero.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      addr_d = last_q ? '0 : addr_q + ADDR_W'(1);
    end
    last_d = (col_d == COL_MAX) && (row_d == ROW_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      last_q <= LAST_AT_ZERO;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      last_q <= last_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;
  assign last_o = last_q;

endmodule

// File: rtl/sprite_blit_engine.sv
// Sweeps an SPR_W x SPR_H rectangle at a runtime position, one clipped pixel write
// per clock, colour from a fill value or an external sprite ROM (optionally keyed).
module sprite_blit_engine
  import blit_pkg::*;
#(
  parameter int unsigned          SPR_W      = 128,
  parameter int unsigned          SPR_H      = 64,
  parameter int unsigned          ADDR_W     = cnt_w(SPR_W * SPR_H),
  parameter int unsigned          COLOUR_W   = 3,
  parameter logic [COLOUR_W-1:0]  KEY_COLOUR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [COORD_X_W-1:0]  pos_x,
  input  logic [COORD_Y_W-1:0]  pos_y,
  input  logic [COLOUR_W-1:0]   fill_colour,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [COLOUR_W-1:0]   rom_q,
  output logic [COORD_X_W-1:0]  x,
  output logic [COORD_Y_W-1:0]  y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned COL_W = cnt_w(SPR_W);
  localparam int unsigned ROW_W = cnt_w(SPR_H);

  blit_state_e          state_q;
  logic                 flush_q;
  blit_mode_e           mode_q;
  logic [COORD_X_W-1:0] pos_x_q;
  logic [COORD_Y_W-1:0] pos_y_q;
  logic [COLOUR_W-1:0]  fill_q;
  blit_stage_t          s1_q;

  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic                 last;

  logic                 clear_c;
  logic                 advance_c;
  logic                 pix_ok_c;
  logic [COLOUR_W-1:0]  pix_colour_c;

  assign clear_c   = (state_q == IDLE) && start;
  assign advance_c = (state_q == RUN);

  blit_raster_counter #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (clear_c),
    .advance_i (advance_c),
    .col_o     (col),
    .row_o     (row),
    .addr_o    (rom_addr),
    .last_o    (last)
  );

  // C1 -> C2 decision: on-screen, and not the key colour when keyed.
  always_comb begin
    pix_colour_c = (mode_q == MODE_FILL) ? fill_q : rom_q;
    pix_ok_c     = s1_q.valid
                && (s1_q.px < PX_W'(SCREEN_W))
                && (s1_q.py < PY_W'(SCREEN_H))
                && !((mode_q == MODE_KEYED) && (rom_q == KEY_COLOUR));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
      mode_q  <= MODE_FILL;
      pos_x_q <= '0;
      pos_y_q <= '0;
      fill_q  <= '0;
      s1_q    <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q  <= decode_mode(mode);
            pos_x_q <= pos_x;
            pos_y_q <= pos_y;
            fill_q  <= fill_colour;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            flush_q <= 1'b0;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // Two cycles let the last issued pixel reach the output register.
          if (flush_q) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            flush_q <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      s1_q.valid <= (state_q == RUN);
      s1_q.px    <= PX_W'(pos_x_q) + PX_W'(col);
      s1_q.py    <= PY_W'(pos_y_q) + PY_W'(row);

      // Suppressed pixels leave x/y/colour holding the last written values.
      plot <= pix_ok_c;
      if (pix_ok_c) begin
        x      <= s1_q.px[COORD_X_W-1:0];
        y      <= s1_q.py[COORD_Y_W-1:0];
        colour <= pix_colour_c;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed bench for sprite_blit_engine with a 4x2 sprite and a registered ROM model.
module tb_sprite_blit_engine;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [8:0] pos_x;
  logic [7:0] pos_y;
  logic [2:0] fill_colour;
  logic [2:0] rom_addr;
  logic [2:0] rom_q;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  logic [2:0] rom [8];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  pix_t       plots[$];
  pix_t       exp_q[$];
  int         done_q[$];

  sprite_blit_engine #(
    .SPR_W (4),
    .SPR_H (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .fill_colour (fill_colour),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rom_q <= rom[rom_addr];
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (plot) plots.push_back('{int'(x), int'(y), int'(colour), cyc});
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_exp(input int ex, input int ey, input int ec, input int et);
    exp_q.push_back('{ex, ey, ec, et});
  endtask

  task automatic run_sweep(input logic [1:0] m, input int px, input int py,
                           input int fc, output int c0);
    bit got;
    @(negedge clock);
    plots.delete();
    done_q.delete();
    mode        = m;
    pos_x       = 9'(px);
    pos_y       = 8'(py);
    fill_colour = 3'(fc);
    start       = 1'b1;
    c0          = cyc;
    @(negedge clock);
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        check("busy_at_done", int'(busy), 0);
        break;
      end
    end
    check("done_seen", int'(got), 1);
    @(negedge clock);
  endtask

  task automatic verify(input string name, input int c0);
    check({name, " plots"}, plots.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < plots.size()) begin
        check($sformatf("%s x[%0d]", name, i), plots[i].x, exp_q[i].x);
        check($sformatf("%s y[%0d]", name, i), plots[i].y, exp_q[i].y);
        check($sformatf("%s c[%0d]", name, i), plots[i].c, exp_q[i].c);
        check($sformatf("%s t[%0d]", name, i), plots[i].t - c0, exp_q[i].t);
      end
    end
    check({name, " dones"}, done_q.size(), 1);
    if (done_q.size() > 0) check({name, " done_cyc"}, done_q[0] - c0, 11);
    exp_q.delete();
  endtask

  initial begin
    int c0;
    int n;
    reset       = 1'b1;
    start       = 1'b0;
    mode        = 2'b00;
    pos_x       = '0;
    pos_y       = '0;
    fill_colour = '0;
    for (int i = 0; i < 8; i++) rom[i] = 3'(i);
    repeat (3) @(negedge clock);
    check("rst plot", int'(plot), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst x", int'(x), 0);
    check("rst y", int'(y), 0);
    check("rst colour", int'(colour), 0);
    check("rst rom_addr", int'(rom_addr), 0);
    reset = 1'b0;

    // Fill at (100,55), colour 7: first plot 3 cycles after the start cycle.
    run_sweep(2'b00, 100, 55, 7, c0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) add_exp(100 + c, 55 + r, 7, 3 + r * 4 + c);
    verify("fill", c0);

    // Draw with ROM 0..7 at origin; colour must track raster order.
    run_sweep(2'b01, 0, 0, 2, c0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) add_exp(c, r, r * 4 + c, 3 + r * 4 + c);
    verify("draw", c0);

    // Keyed, ROM 0,5,0,5..: only odd columns plotted.
    for (int i = 0; i < 8; i++) rom[i] = (i % 2 == 1) ? 3'd5 : 3'd0;
    run_sweep(2'b10, 10, 20, 6, c0);
    add_exp(11, 20, 5, 4);
    add_exp(13, 20, 5, 6);
    add_exp(11, 21, 5, 8);
    add_exp(13, 21, 5, 10);
    verify("keyed", c0);

    // Reserved mode behaves as fill.
    run_sweep(2'b11, 40, 41, 2, c0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) add_exp(40 + c, 41 + r, 2, 3 + r * 4 + c);
    verify("reserved", c0);

    // Bottom-right corner: only two pixels remain on screen.
    run_sweep(2'b00, 318, 239, 3, c0);
    add_exp(318, 239, 3, 3);
    add_exp(319, 239, 3, 4);
    verify("clip", c0);

    // Start held for 20 cycles: one accept, then a re-accept right after done.
    @(negedge clock);
    plots.delete();
    done_q.delete();
    mode        = 2'b00;
    pos_x       = 9'd20;
    pos_y       = 8'd30;
    fill_colour = 3'd2;
    start       = 1'b1;
    c0          = cyc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (cyc == c0 + 20) start = 1'b0;
      if (cyc == c0 + 12) check("hold busy_idle", int'(busy), 0);
      if (cyc == c0 + 13) check("hold busy_reaccept", int'(busy), 1);
    end
    check("hold plots", plots.size(), 16);
    check("hold dones", done_q.size(), 2);
    if (done_q.size() > 1) begin
      check("hold done0", done_q[0] - c0, 11);
      check("hold done1", done_q[1] - c0, 23);
    end
    if (plots.size() > 8) check("hold second_first_plot", plots[8].t - c0, 15);

    // Reset at the 4th plot: in-flight work is dropped and no done follows.
    @(negedge clock);
    plots.delete();
    done_q.delete();
    mode        = 2'b00;
    pos_x       = 9'd50;
    pos_y       = 8'd60;
    fill_colour = 3'd4;
    start       = 1'b1;
    c0          = cyc;
    @(negedge clock);
    start = 1'b0;
    n     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (plot) n++;
      if (n == 4) break;
    end
    check("rst4 plot_cyc", cyc - c0, 6);
    reset = 1'b1;
    @(negedge clock);
    check("rst4 plot", int'(plot), 0);
    check("rst4 busy", int'(busy), 0);
    check("rst4 done", int'(done), 0);
    check("rst4 x", int'(x), 0);
    check("rst4 rom_addr", int'(rom_addr), 0);
    reset = 1'b0;
    done_q.delete();
    repeat (15) @(negedge clock);
    check("rst4 no_done", done_q.size(), 0);

    run_sweep(2'b00, 200, 100, 1, c0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) add_exp(200 + c, 100 + r, 1, 3 + r * 4 + c);
    verify("after_rst", c0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
